// File: rtl/hardmatchblock_param.sv
// Packet header matcher: captures the first HDR_BEATS beats of each packet, matches the
// header against NUM_RULES value/mask rules and queues {hit, dest, tag} results in a show-ahead FIFO.
module hardmatchblock_param #(
  parameter int DATA_W     = 128,
  parameter int TAG_W      = 8,
  parameter int HDR_BEATS  = 2,
  parameter int NUM_RULES  = 4,
  parameter int DEST_W     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int MISS_MODE  = 0,
  localparam int MATCH_W   = HDR_BEATS * DATA_W,
  localparam int AW        = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
  localparam int OUT_W     = 1 + DEST_W + TAG_W
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [TAG_W+2+DATA_W-1:0] pnode_data,
  input  logic                      pnode_valid,
  output logic                      pnode_ready,
  input  logic                      cfg_wr,
  input  logic [AW-1:0]             cfg_addr,
  input  logic                      cfg_en,
  input  logic [MATCH_W-1:0]        cfg_value,
  input  logic [MATCH_W-1:0]        cfg_mask,
  input  logic [DEST_W-1:0]         cfg_dest,
  output logic [OUT_W-1:0]          data_out,
  output logic                      data_valid,
  input  logic                      data_ack,
  output logic [15:0]               drop_count
);

  localparam int SW = $clog2(HDR_BEATS + 1);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = PW - 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SKIP} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [MATCH_W-1:0]   hdr_q, hdr_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 pkt_vld_q, pkt_vld_d;
  logic                 res_vld_q, res_vld_d;
  logic [OUT_W-1:0]     res_q, res_d;
  logic [NUM_RULES-1:0] rule_en_q, rule_en_d;
  logic [MATCH_W-1:0]   rule_val_q [NUM_RULES];
  logic [MATCH_W-1:0]   rule_val_d [NUM_RULES];
  logic [MATCH_W-1:0]   rule_mask_q [NUM_RULES];
  logic [MATCH_W-1:0]   rule_mask_d [NUM_RULES];
  logic [DEST_W-1:0]    rule_dest_q [NUM_RULES];
  logic [DEST_W-1:0]    rule_dest_d [NUM_RULES];
  logic [OUT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]          drop_q, drop_d;

  logic [TAG_W-1:0]  in_tag;
  logic              in_sop, in_eop, beat_acc;
  logic [DATA_W-1:0] in_data;
  logic              abort_drop, miss_drop, full_drop;
  logic              hit;
  logic [DEST_W-1:0] hit_dest;
  logic [PW-1:0]     fifo_cnt;
  logic              fifo_full, pop, wr_en;
  logic [16:0]       drop_sum;

  assign in_tag   = pnode_data[DATA_W+2 +: TAG_W];
  assign in_sop   = pnode_data[DATA_W+1];
  assign in_eop   = pnode_data[DATA_W];
  assign in_data  = pnode_data[DATA_W-1:0];
  assign beat_acc = pnode_valid && pnode_ready;

  // Header capture; a fresh sop always clears the header so short packets are zero-filled
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    hdr_d      = hdr_q;
    tag_d      = tag_q;
    pkt_vld_d  = 1'b0;
    abort_drop = 1'b0;
    if (beat_acc) begin
      if (in_sop) begin
        abort_drop              = (state_q != S_IDLE);
        hdr_d                   = '0;
        hdr_d[DATA_W-1:0]       = in_data;
        slot_d                  = SW'(1);
        state_d                 = (HDR_BEATS == 1) ? S_SKIP : S_CAPTURE;
      end else if (state_q == S_CAPTURE) begin
        hdr_d[slot_q*DATA_W +: DATA_W] = in_data;
        slot_d = slot_q + 1'b1;
        if (slot_q == SW'(HDR_BEATS - 1)) state_d = S_SKIP;
      end
      if (in_eop && (in_sop || state_q != S_IDLE)) begin
        pkt_vld_d = 1'b1;
        tag_d     = in_tag;
        state_d   = S_IDLE;
      end
    end
  end

  // Rule match: scanning downward leaves the lowest-index hit in place
  always_comb begin
    hit      = 1'b0;
    hit_dest = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (rule_en_q[i] && (((hdr_q ^ rule_val_q[i]) & rule_mask_q[i]) == '0)) begin
        hit      = 1'b1;
        hit_dest = rule_dest_q[i];
      end
    end
    res_vld_d = pkt_vld_q && (hit || (MISS_MODE != 0));
    res_d     = hit ? {1'b1, hit_dest, tag_q} : {1'b0, {DEST_W{1'b0}}, tag_q};
    miss_drop = pkt_vld_q && !hit && (MISS_MODE == 0);
  end

  always_comb begin
    rule_en_d   = rule_en_q;
    rule_val_d  = rule_val_q;
    rule_mask_d = rule_mask_q;
    rule_dest_d = rule_dest_q;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (cfg_wr && (cfg_addr == AW'(i))) begin
        rule_en_d[i]   = cfg_en;
        rule_val_d[i]  = cfg_value;
        rule_mask_d[i] = cfg_mask;
        rule_dest_d[i] = cfg_dest;
      end
    end
  end

  // Result FIFO; ready counts the registered result so the FIFO can absorb everything in flight
  assign fifo_cnt    = wr_ptr_q - rd_ptr_q;
  assign fifo_full   = (fifo_cnt == PW'(FIFO_DEPTH));
  assign data_valid  = (fifo_cnt != '0);
  assign data_out    = data_valid ? fifo_mem[rd_ptr_q[IW-1:0]] : '0;
  assign pop         = data_ack && data_valid;
  assign wr_en       = res_vld_q && (!fifo_full || pop);
  assign full_drop   = res_vld_q && fifo_full && !pop;
  assign pnode_ready = (int'(fifo_cnt) + int'(res_vld_q)) < (FIFO_DEPTH - 1);
  assign drop_count  = drop_q;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drop_sum = {1'b0, drop_q} + 17'(abort_drop) + 17'(miss_drop) + 17'(full_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      pkt_vld_q <= 1'b0;
      res_vld_q <= 1'b0;
      rule_en_q <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        rule_val_q[i]  <= '0;
        rule_mask_q[i] <= '0;
        rule_dest_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pkt_vld_q   <= pkt_vld_d;
      res_vld_q   <= res_vld_d;
      rule_en_q   <= rule_en_d;
      rule_val_q  <= rule_val_d;
      rule_mask_q <= rule_mask_d;
      rule_dest_q <= rule_dest_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
    end
  end

  // Datapath registers carry no reset; their valids above qualify them
  always_ff @(posedge clock) begin
    hdr_q <= hdr_d;
    tag_q <= tag_d;
    res_q <= res_d;
    if (wr_en) fifo_mem[wr_ptr_q[IW-1:0]] <= res_q;
  end

endmodule

// File: tb/tb_hardmatchblock_param.sv
// Bench for hardmatchblock_param: two instances (MISS_MODE 0 and 1) share stimulus and are
// checked every cycle against a packet-level model, plus literal expectations per scenario.
module tb_hardmatchblock_param;
  localparam int DW = 128, TW = 8, HB = 2, NR = 4, DSW = 2, FD = 16;
  localparam int MW = HB * DW, OW = 1 + DSW + TW;

  logic              clock = 1'b0;
  logic              resetn;
  logic [TW+2+DW-1:0] pnode_data;
  logic              pnode_valid, cfg_wr, cfg_en, data_ack;
  logic [1:0]        cfg_addr, cfg_dest;
  logic [MW-1:0]     cfg_value, cfg_mask;
  logic [1:0]        rdy, dv;
  logic [OW-1:0]     dout [2];
  logic [15:0]       dcnt [2];

  hardmatchblock_param #(.MISS_MODE(0)) dut0 (
    .clock(clock), .resetn(resetn), .pnode_data(pnode_data), .pnode_valid(pnode_valid),
    .pnode_ready(rdy[0]), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_dest(cfg_dest), .data_out(dout[0]),
    .data_valid(dv[0]), .data_ack(data_ack), .drop_count(dcnt[0]));

  hardmatchblock_param #(.MISS_MODE(1)) dut1 (
    .clock(clock), .resetn(resetn), .pnode_data(pnode_data), .pnode_valid(pnode_valid),
    .pnode_ready(rdy[1]), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_dest(cfg_dest), .data_out(dout[1]),
    .data_valid(dv[1]), .data_ack(data_ack), .drop_count(dcnt[1]));

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Packet-level model: one per instance, instance m uses miss mode m
  logic [MW-1:0]  r_val [NR];
  logic [MW-1:0]  r_mask [NR];
  logic [DSW-1:0] r_dest [NR];
  bit             r_en [NR];
  logic [OW-1:0]  mf [2][FD];
  int             mf_rd [2], mf_cnt [2], nb [2], mdrop [2];
  bit             hv [2], rv [2], inpk [2];
  logic [MW-1:0]  hhdr [2], phdr [2];
  logic [TW-1:0]  htag [2];
  logic [OW-1:0]  rdat [2];
  bit             rdy_now;
  logic [DSW:0]   mr;

  wire [TW-1:0] b_tag  = pnode_data[DW+2 +: TW];
  wire          b_sop  = pnode_data[DW+1];
  wire          b_eop  = pnode_data[DW];
  wire [DW-1:0] b_data = pnode_data[DW-1:0];

  function automatic bit m_ready(input int m);
    return (mf_cnt[m] + (rv[m] ? 1 : 0)) < (FD - 1);
  endfunction

  function automatic logic [DSW:0] match_rules(input logic [MW-1:0] h);
    for (int i = 0; i < NR; i++)
      if (r_en[i] && (((h ^ r_val[i]) & r_mask[i]) == '0)) return {1'b1, r_dest[i]};
    return '0;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int m = 0; m < 2; m++) begin
        mf_rd[m] = 0; mf_cnt[m] = 0; nb[m] = 0; mdrop[m] = 0;
        hv[m] = 0; rv[m] = 0; inpk[m] = 0;
      end
      for (int i = 0; i < NR; i++) begin
        r_en[i] = 0; r_val[i] = '0; r_mask[i] = '0; r_dest[i] = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        rdy_now = m_ready(m);
        if (data_ack && mf_cnt[m] > 0) begin
          mf_rd[m] = (mf_rd[m] + 1) % FD;
          mf_cnt[m]--;
        end
        if (rv[m]) begin
          if (mf_cnt[m] < FD) begin
            mf[m][(mf_rd[m] + mf_cnt[m]) % FD] = rdat[m];
            mf_cnt[m]++;
          end else mdrop[m]++;
          rv[m] = 0;
        end
        if (hv[m]) begin
          mr = match_rules(hhdr[m]);
          if (mr[DSW]) begin
            rv[m] = 1; rdat[m] = {1'b1, mr[DSW-1:0], htag[m]};
          end else if (m == 1) begin
            rv[m] = 1; rdat[m] = {1'b0, {DSW{1'b0}}, htag[m]};
          end else mdrop[m]++;
          hv[m] = 0;
        end
        if (pnode_valid && rdy_now) begin
          if (b_sop) begin
            if (inpk[m]) mdrop[m]++;
            phdr[m] = '0; phdr[m][DW-1:0] = b_data; nb[m] = 1; inpk[m] = 1;
          end else if (inpk[m] && nb[m] < HB) begin
            phdr[m][nb[m]*DW +: DW] = b_data; nb[m]++;
          end
          if (inpk[m] && b_eop) begin
            hv[m] = 1; hhdr[m] = phdr[m]; htag[m] = b_tag; inpk[m] = 0;
          end
        end
        if (mdrop[m] > 65535) mdrop[m] = 65535;
      end
      if (cfg_wr) begin
        r_en[cfg_addr] = cfg_en; r_val[cfg_addr] = cfg_value;
        r_mask[cfg_addr] = cfg_mask; r_dest[cfg_addr] = cfg_dest;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("model_valid%0d", m), dv[m], mf_cnt[m] > 0);
        if (mf_cnt[m] > 0) chk($sformatf("model_head%0d", m), dout[m], mf[m][mf_rd[m]]);
        chk($sformatf("model_ready%0d", m), rdy[m], m_ready(m));
      end
    end
  end

  task automatic beat(input logic [7:0] tg, input bit s, input bit e, input logic [DW-1:0] d);
    bit acc = 1'b0;
    pnode_data  = {tg, s, e, d};
    pnode_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clock); acc = rdy[0];
      @(posedge clock); #1;
    end
    pnode_valid = 1'b0;
    chk("beat_accept", acc, 1'b1);
  endtask

  task automatic cfg_rule(input int idx, input bit en, input logic [MW-1:0] v,
                          input logic [MW-1:0] msk, input logic [1:0] ds);
    cfg_wr = 1'b1; cfg_addr = idx[1:0]; cfg_en = en;
    cfg_value = v; cfg_mask = msk; cfg_dest = ds;
    @(posedge clock); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic pop_expect(input int inst, input logic [OW-1:0] exp, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock); got = dv[inst];
    end
    chk({nm, "_valid"}, got, 1'b1);
    if (got) begin
      chk(nm, dout[inst], exp);
      data_ack = 1'b1;
      @(posedge clock); #1;
      data_ack = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic reset_checks(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk({nm, "_ready"}, rdy[m], 1'b1);
      chk({nm, "_valid"}, dv[m], 1'b0);
      chk({nm, "_dout"}, dout[m], '0);
      chk({nm, "_drop"}, dcnt[m], 16'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  int sent;
  initial begin
    resetn = 1'b0; pnode_valid = 1'b0; pnode_data = '0; data_ack = 1'b0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_value = '0; cfg_mask = '0; cfg_dest = '0;
    @(posedge clock); #1;
    chk_on = 1'b1;
    @(negedge clock);
    reset_checks("reset");
    @(posedge clock); #1;
    resetn = 1'b1;
    wait_cyc(1);

    // Basic hit: tag comes from the eop beat, result visible two edges after eop
    cfg_rule(0, 1'b1, MW'(8'hAB), MW'(8'hFF), 2'b10);
    beat(8'h11, 1'b1, 1'b0, DW'(8'hAB));
    beat(8'h5C, 1'b0, 1'b1, DW'(16'hDEAD));
    @(negedge clock); chk("lat_eop", dv[0], 1'b0);
    @(negedge clock); chk("lat_eop1", dv[0], 1'b0);
    @(negedge clock); chk("lat_eop2", dv[0], 1'b1);
    chk("hit_out0", dout[0], 11'h65C);
    chk("hit_out1", dout[1], 11'h65C);
    pop_expect(0, 11'h65C, "hit_pop");

    // Misses: dropped by instance 0, emitted with hit=0 by instance 1
    beat(8'h21, 1'b1, 1'b1, '0);
    beat(8'h22, 1'b1, 1'b1, '0);
    beat(8'h23, 1'b1, 1'b1, '0);
    wait_cyc(4);
    chk("miss_drop0", dcnt[0], 16'd3);
    chk("miss_drop1", dcnt[1], 16'd0);
    chk("miss_empty0", dv[0], 1'b0);
    pop_expect(1, 11'h021, "miss_e0");
    pop_expect(1, 11'h022, "miss_e1");
    pop_expect(1, 11'h023, "miss_e2");
    @(negedge clock); chk("miss_drained", dv[1], 1'b0);
    @(posedge clock); #1;

    // Priority: rules 1 and 3 hit, disabled rule 2 must not
    cfg_rule(1, 1'b1, MW'(8'h77), MW'(8'hFF), 2'b01);
    cfg_rule(2, 1'b0, MW'(8'h77), MW'(8'hFF), 2'b00);
    cfg_rule(3, 1'b1, MW'(8'h77), MW'(8'hFF), 2'b11);
    beat(8'h31, 1'b1, 1'b0, DW'(8'h77));
    beat(8'h32, 1'b0, 1'b1, DW'(16'h1234));
    pop_expect(0, 11'h532, "prio");

    // Rule 0 requires slot 1 all-zero: single-beat hits, 2-beat with nonzero slot 1 falls to rule 1
    cfg_rule(0, 1'b1, '0, {{DW{1'b1}}, {DW{1'b0}}}, 2'b11);
    beat(8'h33, 1'b1, 1'b1, DW'(8'h55));
    beat(8'h34, 1'b1, 1'b0, DW'(8'h77));
    beat(8'h35, 1'b0, 1'b1, DW'(1));
    pop_expect(0, 11'h733, "zero_slot");
    pop_expect(0, 11'h535, "slot1_set");

    // sop during capture abandons the first packet
    beat(8'h41, 1'b1, 1'b0, DW'(8'h55));
    beat(8'h42, 1'b1, 1'b0, DW'(8'h77));
    beat(8'h43, 1'b0, 1'b1, DW'(9));
    wait_cyc(3);
    chk("abort_drop0", dcnt[0], 16'd4);
    chk("abort_drop1", dcnt[1], 16'd1);
    pop_expect(0, 11'h543, "abort_second");
    @(negedge clock); chk("abort_only_one", dv[0], 1'b0);
    @(posedge clock); #1;

    // Reset pulsed mid-packet, then an orphan eop must be ignored
    beat(8'h51, 1'b1, 1'b0, DW'(8'h77));
    #2 resetn = 1'b0;
    @(negedge clock);
    reset_checks("midreset");
    @(posedge clock); #1;
    resetn = 1'b1;
    beat(8'h52, 1'b0, 1'b1, DW'(8'h77));
    wait_cyc(4);
    chk("orphan_drop0", dcnt[0], 16'd0);
    chk("orphan_valid1", dv[1], 1'b0);

    // Backpressure: stream single-beat hits with no acks until ready stays low
    cfg_rule(0, 1'b1, '0, '0, 2'b10);
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      pnode_data  = {8'(sent), 1'b1, 1'b1, DW'(sent)};
      pnode_valid = 1'b1;
      @(negedge clock);
      if (rdy[0]) sent++;
      @(posedge clock); #1;
    end
    pnode_valid = 1'b0;
    wait_cyc(4);
    chk("fill_accepted", sent, 16);
    chk("fill_ready", rdy[0], 1'b0);
    chk("fill_drop0", dcnt[0], 16'd0);
    chk("fill_drop1", dcnt[1], 16'd0);
    for (int i = 0; i < FD; i++) pop_expect(0, {1'b1, 2'b10, 8'(i)}, $sformatf("drain%0d", i));
    @(negedge clock); chk("drain_empty", dv[0], 1'b0);
    chk("drain_ready", rdy[0], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hardmatchblock_param.md
HARDMATCHBLOCK_PARAM -- requirements
Module: hardmatchblock_param

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the packet data beat width in bits.
REQ-002 SHALL have parameter TAG_W, default 8, meaning the width of the per-packet tag carried in the top bits of pnode_data.
REQ-003 SHALL have parameter HDR_BEATS, default 2, meaning the number of leading beats captured as the header; MATCH_W = HDR_BEATS*DATA_W.
REQ-004 SHALL have parameter NUM_RULES, default 4, meaning the number of value/mask match rules.
REQ-005 SHALL have parameter DEST_W, default 2, meaning the width of the per-rule destination field.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >=4), meaning the result FIFO entry count.
REQ-007 SHALL have parameter MISS_MODE, default 0, meaning 0 = drop non-matching packets and 1 = emit them with hit=0.
REQ-008 SHALL have the ports below; one clock; reset is asynchronous and active-low.
- clock  in  1  sole clock
- resetn  in  1  async active-low reset
- pnode_data  in  TAG_W+2+DATA_W  {tag, sop, eop, data}, tag MSB-aligned
- pnode_valid  in  1  beat valid
- pnode_ready  out  1  beat accept
- cfg_wr  in  1  rule write strobe
- cfg_addr  in  clog2(NUM_RULES)  rule index
- cfg_en  in  1  rule enable
- cfg_value  in  MATCH_W  match value
- cfg_mask  in  MATCH_W  compare mask (1 = compared)
- cfg_dest  in  DEST_W  rule destination
- data_out  out  1+DEST_W+TAG_W  {hit, dest, tag}, FIFO head
- data_valid  out  1  FIFO not empty
- data_ack  in  1  pop FIFO head
- drop_count  out  16  saturating dropped-packet count

Function
REQ-009 SHALL treat a beat as accepted only when pnode_valid && pnode_ready.
REQ-010 SHALL run the capture FSM IDLE -> CAPTURE -> SKIP: IDLE + accepted sop stores beat 0 and enters CAPTURE; CAPTURE stores beat k at header slot k until HDR_BEATS are stored, then enters SKIP; an accepted eop in any state returns to IDLE.
REQ-011 SHALL place beat k at header bits [k*DATA_W +: DATA_W] and zero the unfilled slots when eop arrives before HDR_BEATS beats.
REQ-012 SHALL ignore accepted beats without sop in IDLE.
REQ-013 SHALL, on an accepted sop while in CAPTURE or SKIP, abandon the open packet, increment drop_count, and restart capture with this beat.
REQ-014 SHALL latch the tag from the accepted eop beat, not from the sop beat.
REQ-015 SHALL evaluate rule i as hit when it is enabled and ((header ^ value_i) & mask_i) == 0; the lowest hit index wins.
REQ-016 SHALL register the match result on the cycle after eop acceptance (T+1) and write the FIFO at the T+2 edge, so that data_valid is first high at T+2 from an empty FIFO.
REQ-017 SHALL write {1, dest_i, tag} on a hit; on a miss, it SHALL write {0, 0, tag} when MISS_MODE=1, and when MISS_MODE=0 it SHALL write nothing and increment drop_count.
REQ-018 SHALL make a single-beat packet (sop && eop) a complete packet with header slot 0 only.
REQ-019 SHALL drive pnode_ready = (fifo_count + in_flight_results) < FIFO_DEPTH-1, with in_flight counting T+1/T+2 results not yet written.
REQ-020 SHALL present the FIFO in show-ahead form (data_out valid whenever data_valid) and pop on data_ack && data_valid; data_ack while empty is ignored.
REQ-021 SHALL apply a write and a pop in the same cycle with the count unchanged; if a write finds the FIFO full with no pop, the entry is discarded and drop_count increments.
REQ-022 SHALL apply a cfg_wr on the following cycle: a compare in the write cycle uses the old rule, and a compare in the next cycle uses the new rule.
REQ-023 SHALL saturate drop_count at 16'hFFFF, and simultaneous drop sources in one cycle SHALL add their sum, saturating.

Reset
REQ-024 SHALL, while resetn=0, put the FSM in IDLE, disable all rules with value, mask and dest set to 0, empty the FIFO, clear the in-flight results, and drive data_valid=0, data_out=0, drop_count=0 and pnode_ready=1.
REQ-025 SHALL discard a packet in progress at reset without counting it.

Verification
REQ-026 SHALL cover: rule0 en, mask on byte 0, value 8'hAB, dest 2'b10; 2-beat packet with byte0=AB and tag 8'h5C -> data_out={1,2'b10,8'h5C}, data_valid at eop+2.
REQ-027 SHALL cover: MISS_MODE=0 and no rule hit, three packets -> no FIFO write and drop_count=3; with MISS_MODE=1 -> three entries {0,0,tag}.
REQ-028 SHALL cover: rules 1 and 3 both hit -> dest from rule 1; a single-beat packet matching zero-filled slot 1 -> hit.
REQ-029 SHALL cover: data_ack held 0 with back-to-back single-beat packets -> pnode_ready falls before any FIFO overflow, drop_count=0, and all FIFO_DEPTH entries are drained in order.
REQ-030 SHALL cover: sop during CAPTURE -> drop_count+1 and only the second packet is reported; resetn pulsed mid-packet -> all outputs at reset values and no count.
